dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU MEM stage (port p1) and the 256-bit line-wide Data_Memory. It resolves 32-bit loads/stores in zero extra cycles on a hit. On a miss it stalls the pipeline, writes back the victim line if dirty, and refills the line over a level enable/ack handshake. The block holds 32 lines of 256 bits, indexed by addr[9:5].

## Interface
Parameters:
- LINES, 32, number of cache lines; index width is log2(LINES).
- LINE_W, 256, line width in bits (8 words).
- TAG_W, 22, address tag width, taken from addr[31:10].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- p1_addr_i  in  32  CPU byte address; word select is addr[4:2].
- p1_data_i  in  32  store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data, combinational.
- p1_stall_o  out  1  pipeline stall, combinational.
- mem_addr_o  out  32  line address sent to memory; low 5 bits always 0.
- mem_data_o  out  256  write-back line.
- mem_enable_o  out  1  memory request, level-held until ack.
- mem_write_o  out  1  1 = write-back, 0 = refill read.
- mem_data_i  in  256  refill line; valid in the ack cycle.
- mem_ack_i  in  1  one-cycle acknowledge from memory.

## Operation
- Tag SRAM entry is 24 bits: {valid, dirty, tag[21:0]}. Data SRAM entry is 256 bits. Neither array is reset; the bench initialises both.
- Hit: (MemRead | MemWrite) & valid & (stored tag == addr[31:10]).
- Read hit: p1_data_o = line word addr[4:2]; stall = 0.
- Write hit: at the posedge, word addr[4:2] ← p1_data_i and dirty ← 1; stall = 0.
- p1_data_o always shows the indexed line's selected word. Its value is don't-care when no request is present.
- MemRead and MemWrite asserted together is illegal; write takes priority.
- FSM states (encoding fixed, because the bench reads state==0):
  - IDLE = 0: on a request that misses, go to MISS.
  - MISS = 1:
    - If the victim is valid & dirty: go to WRITEBACK with mem_enable = 1, mem_write = 1, mem_addr = {old tag, index, 5'b0}, mem_data = old line.
    - Otherwise: go to READMISS with mem_enable = 1, mem_write = 0, mem_addr = {req tag, index, 5'b0}.
  - WRITEBACK = 4: hold all mem outputs until mem_ack_i. On ack, go to READMISS with mem_write = 0, mem_addr = {req tag, index, 5'b0}, and mem_enable kept at 1.
  - READMISS = 2: hold until mem_ack_i. On ack, capture mem_data_i into the data SRAM, set tag entry = {1, 0, req tag}, drop mem_enable, go to READMISSOK.
  - READMISSOK = 3: go to IDLE. The request is then re-evaluated as a hit; a store merges its word and sets dirty.
- p1_stall_o = (state != IDLE) | (request & !hit).
- mem_enable_o, mem_write_o and mem_addr_o are registered. mem_data_o is the victim line latched on entry to WRITEBACK.

## Timing
- Reset values: state IDLE, mem_enable_o 0, mem_write_o 0, mem_addr_o 0, mem_data_o 0. p1_stall_o is 0 while no request is present.
- Hit latency: 0 stall cycles.
- Clean miss: stall covers IDLE(1) + MISS(1) + READMISS(N) + READMISSOK(1), where N is the number of cycles from enable to ack, N ≥ 1. The request completes in the following IDLE cycle.
- Dirty miss: add WRITEBACK(M) cycles ahead of READMISS.
- The memory may ack after any delay. The controller never drops mem_enable_o before ack and ignores mem_ack_i in IDLE/MISS/READMISSOK.
- Back-to-back ack (a write-back ack followed immediately by the refill) is legal. Refill enable stays high across the transition with only mem_write_o toggling.
- The CPU holds p1_addr_i, p1_data_i and the request bits stable while stalled.
- Reset asserted mid-miss: return to IDLE and drop mem_enable immediately. The partially fetched line is discarded; SRAM contents are left as they were.

## Structure
- Shared package dcache_pkg holds:
  - state encodings;
  - TAG_W, LINE_W, index/offset bit positions;
  - the tag-entry field positions (VALID_BIT = 23, DIRTY_BIT = 22).
- One sub-module, dcache_sram, is instantiated twice: as dcache_tag_sram (24 bits wide) and as dcache_data_sram (256 bits wide).
  - Each has 32 entries, a synchronous write and a combinational read.
  - Each exposes a memory array so the bench can preload and flush it.

## Test plan
- Cold read of 0x0000 (tag entry 0, memory line 0 = 0x5) -> stall asserted; exactly one READMISS request to address 0x00000000; p1_data_o = 0x00000005 after refill; tag[0] = {1, 0, 0}.
- Write hit at 0x0004, data 0xDEADBEEF, after that refill -> no stall; line 0 word 1 = 0xDEADBEEF; dirty = 1.
- Read 0x0400 (same index 0, tag 1) with line 0 dirty -> WRITEBACK to 0x00000000 carrying 0xDEADBEEF in word 1, then READMISS at 0x00000400; memory line 0 updated; tag[0] = {1, 0, 1}.
- Memory ack delayed 10 cycles -> mem_enable_o held 10 cycles; stall held throughout; no SRAM change before ack.
- Reset pulled low during READMISS -> next cycle: state 0, mem_enable_o 0, stall 0; tag entry unchanged.
- Write miss to 0x0024 (data 0x12345678, clean victim) -> refill of line 1, then word 1 = 0x12345678 with dirty = 1.

Source files
------------

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared state encodings, field positions and helpers for the
//            direct-mapped write-back L1 data cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  // Geometry of the default configuration
  localparam int LINES       = 32;
  localparam int IDX_W       = 5;
  localparam int LINE_W      = 256;
  localparam int WORD_W      = 32;
  localparam int TAG_W       = 22;
  localparam int TAG_ENTRY_W = 24;

  // Address field positions
  localparam int OFFSET_LSB  = 2;
  localparam int OFFSET_MSB  = 4;
  localparam int IDX_LSB     = 5;
  localparam int IDX_MSB     = 9;
  localparam int TAG_LSB     = 10;
  localparam int TAG_MSB     = 31;

  // Tag-entry layout: {valid, dirty, tag}
  localparam int VALID_BIT   = 23;
  localparam int DIRTY_BIT   = 22;

  // Controller states; the numeric encoding is externally visible
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MISS       = 3'd1,
    ST_READMISS   = 3'd2,
    ST_READMISSOK = 3'd3,
    ST_WRITEBACK  = 3'd4
  } state_t;

  // Replace one 32-bit word of a line, leaving the other words intact
  function automatic logic [LINE_W-1:0] merge_word(
    input logic [LINE_W-1:0] line,
    input logic [2:0]        sel,
    input logic [WORD_W-1:0] data
  );
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[{sel, 5'b00000} +: WORD_W] = data;
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sram
// Purpose  : Single-port storage array with synchronous write and
//            combinational read, used for both the tag and data arrays.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_sram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  // Contents are not reset; they are loaded externally before use
  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write port
  always @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Purpose  : Direct-mapped, write-back, write-allocate L1 data cache between
//            the CPU MEM stage and a line-wide data memory. Hits resolve with
//            no stall; misses write back a dirty victim and refill the line.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_controller #(
  parameter int LINES  = 32,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  import dcache_pkg::*;

  localparam int C_IDX_W   = $clog2(LINES);
  localparam int C_ENTRY_W = TAG_W + 2;

  // Address decomposition
  logic [C_IDX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_req_tag;
  logic [2:0]         w_word_sel;
  logic               w_unused;

  assign w_index    = p1_addr_i[IDX_LSB +: C_IDX_W];
  assign w_req_tag  = p1_addr_i[31 -: TAG_W];
  assign w_word_sel = p1_addr_i[OFFSET_MSB:OFFSET_LSB];
  assign w_unused   = ^p1_addr_i[1:0];

  // Array read/write buses
  logic [C_ENTRY_W-1:0] w_tag_entry;
  logic [LINE_W-1:0]    w_line;
  logic                 w_tag_we;
  logic [C_ENTRY_W-1:0] w_tag_wdata;
  logic                 w_data_we;
  logic [LINE_W-1:0]    w_data_wdata;

  // Registered state and memory-side outputs
  state_t               r_state;
  logic                 r_mem_enable;
  logic                 r_mem_write;
  logic [31:0]          r_mem_addr;
  logic [LINE_W-1:0]    r_mem_data;

  // Hit detection
  logic w_req;
  logic w_hit;

  assign w_req = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit = w_req & w_tag_entry[VALID_BIT] &
                 (w_tag_entry[TAG_W-1:0] == w_req_tag);

  assign p1_data_o    = w_line[{w_word_sel, 5'b00000} +: 32];
  assign p1_stall_o   = (r_state != ST_IDLE) | (w_req & ~w_hit);
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

  dcache_sram #(
    .WIDTH (C_ENTRY_W),
    .DEPTH (LINES)
  ) dcache_tag_sram (
    .clk_i   (clk_i),
    .we_i    (w_tag_we),
    .addr_i  (w_index),
    .wdata_i (w_tag_wdata),
    .rdata_o (w_tag_entry)
  );

  dcache_sram #(
    .WIDTH (LINE_W),
    .DEPTH (LINES)
  ) dcache_data_sram (
    .clk_i   (clk_i),
    .we_i    (w_data_we),
    .addr_i  (w_index),
    .wdata_i (w_data_wdata),
    .rdata_o (w_line)
  );

  // Array updates: refill on ack, or store merge on a hit; blocked in reset
  always_comb begin
    w_tag_we     = 1'b0;
    w_tag_wdata  = '0;
    w_data_we    = 1'b0;
    w_data_wdata = '0;
    if (rst_i) begin
      if ((r_state == ST_READMISS) && mem_ack_i) begin
        w_tag_we     = 1'b1;
        w_tag_wdata  = {1'b1, 1'b0, w_req_tag};
        w_data_we    = 1'b1;
        w_data_wdata = mem_data_i;
      end else if ((r_state == ST_IDLE) && p1_MemWrite_i && w_hit) begin
        w_tag_we     = 1'b1;
        w_tag_wdata  = {1'b1, 1'b1, w_req_tag};
        w_data_we    = 1'b1;
        w_data_wdata = merge_word(w_line, w_word_sel, p1_data_i);
      end
    end
  end

  // Miss-handling FSM with registered memory request outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !w_hit) begin
            r_state <= ST_MISS;
          end
        end
        ST_MISS: begin
          r_mem_enable <= 1'b1;
          if (w_tag_entry[VALID_BIT] && w_tag_entry[DIRTY_BIT]) begin
            r_state     <= ST_WRITEBACK;
            r_mem_write <= 1'b1;
            r_mem_addr  <= {w_tag_entry[TAG_W-1:0], w_index, 5'b00000};
            r_mem_data  <= w_line;
          end else begin
            r_state     <= ST_READMISS;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {w_req_tag, w_index, 5'b00000};
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            r_state     <= ST_READMISS;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {w_req_tag, w_index, 5'b00000};
          end
        end
        ST_READMISS: begin
          if (mem_ack_i) begin
            r_state      <= ST_READMISSOK;
            r_mem_enable <= 1'b0;
          end
        end
        ST_READMISSOK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_mem_enable <= 1'b0;
          r_mem_write  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_controller
// Purpose  : Directed self-checking bench for dcache_controller with a
//            line-wide memory responder of programmable ack delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  p1_addr = '0;
  logic [31:0]  p1_wdata = '0;
  logic         p1_rd = 1'b0;
  logic         p1_wr = 1'b0;
  logic [31:0]  p1_rdata;
  logic         p1_stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_enable;
  logic         mem_write;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .p1_addr_i     (p1_addr),
    .p1_data_i     (p1_wdata),
    .p1_MemRead_i  (p1_rd),
    .p1_MemWrite_i (p1_wr),
    .p1_data_o     (p1_rdata),
    .p1_stall_o    (p1_stall),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_enable_o  (mem_enable),
    .mem_write_o   (mem_write),
    .mem_data_i    (mem_rdata),
    .mem_ack_i     (mem_ack)
  );

  int checks = 0;
  int errors = 0;

  logic [255:0] mem_model [0:127];
  int           ack_delay = 1;
  int           wait_cnt = 0;
  int           rd_count = 0;
  int           wb_count = 0;
  int           en_cycles = 0;
  logic [31:0]  rd_addr = '0;
  logic [31:0]  wb_addr = '0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_delay enabled cycles, one-cycle pulse
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_enable) begin
        if (wait_cnt + 1 >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_write) begin
            mem_model[mem_addr[11:5]] = mem_wdata;
            wb_count++;
            wb_addr = mem_addr;
          end else begin
            mem_rdata = mem_model[mem_addr[11:5]];
            rd_count++;
            rd_addr = mem_addr;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_enable) en_cycles++;
  end

  // Present one request, hold it while stalled, and return the stall count
  task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic is_write, input int delay,
                         output int stall_cyc, output logic [31:0] rdata,
                         output logic [23:0] tag_pre_ack);
    ack_delay = delay;
    @(negedge clk);
    p1_addr  = addr;
    p1_wdata = wdata;
    p1_wr    = is_write;
    p1_rd    = !is_write;
    stall_cyc = 0;
    tag_pre_ack = dut.dcache_tag_sram.mem[addr[9:5]];
    #1;
    for (int c = 0; c < 400 && p1_stall; c++) begin
      stall_cyc++;
      if (mem_enable && !mem_ack) tag_pre_ack = dut.dcache_tag_sram.mem[addr[9:5]];
      @(negedge clk);
      #1;
    end
    check_val("stall_release", {255'b0, p1_stall}, 256'd0);
    rdata = p1_rdata;
    @(negedge clk);
    p1_rd = 1'b0;
    p1_wr = 1'b0;
  endtask

  initial begin
    int          sc;
    logic [31:0] rd;
    logic [23:0] tpre;
    int          rd0, wb0, en0;

    for (int i = 0; i < 32; i++) begin
      dut.dcache_tag_sram.mem[i]  = '0;
      dut.dcache_data_sram.mem[i] = '0;
    end
    for (int i = 0; i < 128; i++) begin
      for (int k = 0; k < 8; k++) begin
        mem_model[i][k*32 +: 32] = 32'h1100_0000 | (32'(i) << 8) | 32'(k);
      end
    end
    mem_model[0][31:0] = 32'h0000_0005;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_state", {253'b0, dut.r_state}, 256'd0);
    check_val("rst_enable", {255'b0, mem_enable}, 256'd0);
    check_val("rst_write", {255'b0, mem_write}, 256'd0);
    check_val("rst_addr", {224'b0, mem_addr}, 256'd0);
    check_val("rst_data", mem_wdata, 256'd0);
    check_val("rst_stall", {255'b0, p1_stall}, 256'd0);
    rst_n = 1'b1;

    // Cold read miss of 0x0000
    rd0 = rd_count; wb0 = wb_count;
    run_req(32'h0000_0000, 32'h0, 1'b0, 1, sc, rd, tpre);
    check_val("cold_stall_cycles", 256'(sc), 256'd4);
    check_val("cold_data", {224'b0, rd}, 256'h5);
    check_val("cold_rd_count", 256'(rd_count - rd0), 256'd1);
    check_val("cold_rd_addr", {224'b0, rd_addr}, 256'h0);
    check_val("cold_wb_count", 256'(wb_count - wb0), 256'd0);
    check_val("cold_tag0", {232'b0, dut.dcache_tag_sram.mem[0]}, 256'h80_0000);

    // Write hit 0x0004, then read hits on words 1 and 7
    @(negedge clk);
    p1_addr = 32'h0000_0004; p1_wdata = 32'hDEAD_BEEF; p1_wr = 1'b1;
    #1;
    check_val("wrhit_stall", {255'b0, p1_stall}, 256'd0);
    @(negedge clk);
    p1_wr = 1'b0;
    check_val("wrhit_word1", {224'b0, dut.dcache_data_sram.mem[0][63:32]}, 256'hDEAD_BEEF);
    check_val("wrhit_word0", {224'b0, dut.dcache_data_sram.mem[0][31:0]}, 256'h5);
    check_val("wrhit_tag0", {232'b0, dut.dcache_tag_sram.mem[0]}, 256'hC0_0000);
    p1_rd = 1'b1;
    #1;
    check_val("rdhit_w1_data", {224'b0, p1_rdata}, 256'hDEAD_BEEF);
    check_val("rdhit_w1_stall", {255'b0, p1_stall}, 256'd0);
    p1_addr = 32'h0000_001C;
    #1;
    check_val("rdhit_w7_data", {224'b0, p1_rdata}, 256'h1100_0007);
    @(negedge clk);
    p1_rd = 1'b0;

    // Dirty miss 0x0400: write-back then refill
    rd0 = rd_count; wb0 = wb_count; en0 = en_cycles;
    run_req(32'h0000_0400, 32'h0, 1'b0, 3, sc, rd, tpre);
    check_val("dirty_stall_cycles", 256'(sc), 256'd10);
    check_val("dirty_data", {224'b0, rd}, 256'h1100_2000);
    check_val("dirty_wb_count", 256'(wb_count - wb0), 256'd1);
    check_val("dirty_wb_addr", {224'b0, wb_addr}, 256'h0);
    check_val("dirty_mem_w1", {224'b0, mem_model[0][63:32]}, 256'hDEAD_BEEF);
    check_val("dirty_mem_w0", {224'b0, mem_model[0][31:0]}, 256'h5);
    check_val("dirty_rd_addr", {224'b0, rd_addr}, 256'h400);
    check_val("dirty_rd_count", 256'(rd_count - rd0), 256'd1);
    check_val("dirty_en_cycles", 256'(en_cycles - en0), 256'd7);
    check_val("dirty_tag0", {232'b0, dut.dcache_tag_sram.mem[0]}, 256'h80_0001);

    // Clean miss 0x0800 with a 10-cycle ack delay
    rd0 = rd_count; wb0 = wb_count; en0 = en_cycles;
    run_req(32'h0000_0800, 32'h0, 1'b0, 10, sc, rd, tpre);
    check_val("slow_stall_cycles", 256'(sc), 256'd13);
    check_val("slow_en_cycles", 256'(en_cycles - en0), 256'd10);
    check_val("slow_tag_pre_ack", {232'b0, tpre}, 256'h80_0001);
    check_val("slow_data", {224'b0, rd}, 256'h1100_4000);
    check_val("slow_wb_count", 256'(wb_count - wb0), 256'd0);
    check_val("slow_tag0", {232'b0, dut.dcache_tag_sram.mem[0]}, 256'h80_0002);

    // Reset asserted during READMISS
    ack_delay = 20;
    @(negedge clk);
    p1_addr = 32'h0000_0C00; p1_rd = 1'b1;
    for (int c = 0; c < 20 && !mem_enable; c++) @(negedge clk);
    check_val("rstmid_enable_seen", {255'b0, mem_enable}, 256'd1);
    repeat (3) @(negedge clk);
    check_val("rstmid_in_readmiss", {253'b0, dut.r_state}, 256'd2);
    rst_n = 1'b0; p1_rd = 1'b0;
    #1;
    check_val("rstmid_state", {253'b0, dut.r_state}, 256'd0);
    check_val("rstmid_enable", {255'b0, mem_enable}, 256'd0);
    check_val("rstmid_stall", {255'b0, p1_stall}, 256'd0);
    check_val("rstmid_tag0", {232'b0, dut.dcache_tag_sram.mem[0]}, 256'h80_0002);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_val("rstmid_tag0_after", {232'b0, dut.dcache_tag_sram.mem[0]}, 256'h80_0002);

    // Write miss 0x0024 to a clean (invalid) victim in line 1
    rd0 = rd_count; wb0 = wb_count;
    run_req(32'h0000_0024, 32'h1234_5678, 1'b1, 2, sc, rd, tpre);
    check_val("wmiss_stall_cycles", 256'(sc), 256'd5);
    check_val("wmiss_rd_addr", {224'b0, rd_addr}, 256'h20);
    check_val("wmiss_rd_count", 256'(rd_count - rd0), 256'd1);
    check_val("wmiss_wb_count", 256'(wb_count - wb0), 256'd0);
    check_val("wmiss_word1", {224'b0, dut.dcache_data_sram.mem[1][63:32]}, 256'h1234_5678);
    check_val("wmiss_word0", {224'b0, dut.dcache_data_sram.mem[1][31:0]}, 256'h1100_0100);
    check_val("wmiss_tag1", {232'b0, dut.dcache_tag_sram.mem[1]}, 256'hC0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
